// File: rtl/ram_initiator.sv
// Burst command initiator for a dual-port RAM: streams write bursts into the
// write port and issues read bursts, returning read data on a response stream.
module ram_initiator #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_wr_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_rd_address,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_remaining;
  logic                    r_ram_write;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_data_in;
  logic                    r_ram_read;
  logic                    r_rd_last;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [RD_LATENCY:1]     r_pipe_vld;
  logic [RD_LATENCY:1]     r_pipe_last;
  logic                    r_rsp_valid;
  logic                    r_rsp_last;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic                    w_rem_zero;
  logic                    w_drained;
  logic [RD_LATENCY:0]     w_vld_chain;
  logic [RD_LATENCY:0]     w_last_chain;

  assign w_rem_zero   = (r_remaining == '0);
  // Stage 0 of each chain is the registered strobe currently seen by the RAM.
  assign w_vld_chain  = {r_pipe_vld, r_ram_read};
  assign w_last_chain = {r_pipe_last, r_ram_read & r_rd_last};
  assign w_drained    = !r_ram_read && (r_pipe_vld == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_state_nxt = cmd_write ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid && w_rem_zero) w_state_nxt = S_IDLE;
      end
      S_READ:  if (w_rem_zero) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_ram_write <= 1'b0;
      r_wr_addr   <= '0;
      r_data_in   <= '0;
      r_ram_read  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_ram_write <= 1'b0;
      r_ram_read  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_addr;
            r_remaining <= cmd_len;
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            r_ram_write <= 1'b1;
            r_wr_addr   <= r_addr;
            r_data_in   <= wr_data;
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
        end
        S_READ: begin
          r_ram_read  <= 1'b1;
          r_rd_addr   <= r_addr;
          r_rd_last   <= w_rem_zero;
          r_addr      <= r_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_pipe_vld  <= w_vld_chain[RD_LATENCY-1:0];
      r_pipe_last <= w_last_chain[RD_LATENCY-1:0];
      r_rsp_valid <= r_pipe_vld[RD_LATENCY];
      r_rsp_last  <= r_pipe_vld[RD_LATENCY] & r_pipe_last[RD_LATENCY];
      if (r_pipe_vld[RD_LATENCY]) r_rsp_data <= ram_data_out;
    end
  end

  assign ram_write      = r_ram_write;
  assign ram_wr_address = r_wr_addr;
  assign ram_data_in    = r_data_in;
  assign ram_read       = r_ram_read;
  assign ram_rd_address = r_rd_addr;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_last       = r_rsp_last;
  assign rsp_data       = r_rsp_data;

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator: one instance with a behavioural RAM
// (RD_LATENCY=1) and one with a latency-3 address-echo RAM.
module tb_ram_initiator;

  logic        clk;
  logic        resetn;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic        rsp_valid, rsp_last, busy;
  logic [63:0] rsp_data;
  logic        ram_write, ram_read;
  logic [11:0] ram_wr_address, ram_rd_address;
  logic [63:0] ram_data_in, ram_data_out;

  logic        cmd_valid3, cmd_ready3, cmd_write3;
  logic [11:0] cmd_addr3;
  logic [7:0]  cmd_len3;
  logic        wr_valid3, wr_ready3;
  logic [63:0] wr_data3;
  logic        rsp_valid3, rsp_last3, busy3;
  logic [63:0] rsp_data3;
  logic        ram_write3, ram_read3;
  logic [11:0] ram_wr_address3, ram_rd_address3;
  logic [63:0] ram_data_in3, ram_data_out3;

  logic [63:0] mem [4096];
  logic [63:0] rd_q;
  logic [63:0] s1, s2, s3;

  int n_pass  = 0;
  int n_total = 0;

  ram_initiator #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .RD_LATENCY(1)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy),
    .ram_write(ram_write), .ram_wr_address(ram_wr_address), .ram_data_in(ram_data_in),
    .ram_read(ram_read), .ram_rd_address(ram_rd_address), .ram_data_out(ram_data_out)
  );

  ram_initiator #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .RD_LATENCY(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write3),
    .cmd_addr(cmd_addr3), .cmd_len(cmd_len3),
    .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_data(wr_data3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_last(rsp_last3),
    .busy(busy3),
    .ram_write(ram_write3), .ram_wr_address(ram_wr_address3), .ram_data_in(ram_data_in3),
    .ram_read(ram_read3), .ram_rd_address(ram_rd_address3), .ram_data_out(ram_data_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) mem[ram_wr_address] <= ram_data_in;
    if (ram_read)  rd_q <= mem[ram_rd_address];
  end
  assign ram_data_out = rd_q;

  // Latency-3 RAM whose contents are a fixed function of the address.
  always @(posedge clk) begin
    s1 <= ram_read3 ? (64'hC0DE_0000_0000_0000 | 64'(ram_rd_address3)) : 64'h0;
    s2 <= s1;
    s3 <= s2;
  end
  assign ram_data_out3 = s3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [7:0] len, input logic [63:0] base);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    wr_valid  = 1'b1; wr_data = base;
    tick();
    cmd_valid = 1'b0;
    chk("wr_accept_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("wr_accept_busy",      64'(busy),      64'd1);
    chk("wr_accept_wr_ready",  64'(wr_ready),  64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wr_data = base + 64'(i);
      tick();
      chk("wr_ram_write", 64'(ram_write),      64'd1);
      chk("wr_address",   64'(ram_wr_address), 64'(12'(addr + 12'(i))));
      chk("wr_data_in",   ram_data_in,         base + 64'(i));
      if (i < int'(len)) chk("wr_cmd_ready_low", 64'(cmd_ready), 64'd0);
    end
    chk("wr_end_busy",      64'(busy),      64'd0);
    chk("wr_end_wr_ready",  64'(wr_ready),  64'd0);
    chk("wr_end_cmd_ready", 64'(cmd_ready), 64'd1);
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] addr, input logic [7:0] len, input logic [63:0] base);
    bit exp_rd, exp_v;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    chk("rd_accept_ram_write", 64'(ram_write), 64'd0);
    chk("rd_accept_ram_read",  64'(ram_read),  64'd0);
    for (int j = 0; j <= int'(len) + 3; j++) begin
      tick();
      exp_rd = (j <= int'(len));
      exp_v  = (j >= 2) && (j <= int'(len) + 2);
      chk("rd_ram_read", 64'(ram_read), 64'(exp_rd));
      if (exp_rd) chk("rd_address", 64'(ram_rd_address), 64'(12'(addr + 12'(j))));
      chk("rd_rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v) begin
        chk("rd_rsp_data", rsp_data, base + 64'(j - 2));
        chk("rd_rsp_last", 64'(rsp_last), 64'(j == int'(len) + 2));
      end
      if (j == int'(len) + 3) begin
        chk("rd_end_busy",      64'(busy),      64'd0);
        chk("rd_end_cmd_ready", 64'(cmd_ready), 64'd1);
      end else begin
        chk("rd_busy", 64'(busy), 64'd1);
      end
    end
  endtask

  initial begin
    logic [6:0] stall_pat;
    int b;

    resetn    = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid  = 1'b0; wr_data = '0;
    cmd_valid3 = 1'b0; cmd_write3 = 1'b0; cmd_addr3 = '0; cmd_len3 = '0;
    wr_valid3  = 1'b0; wr_data3 = '0;
    repeat (3) tick();

    chk("rst_cmd_ready",  64'(cmd_ready),      64'd1);
    chk("rst_busy",       64'(busy),           64'd0);
    chk("rst_wr_ready",   64'(wr_ready),       64'd0);
    chk("rst_ram_write",  64'(ram_write),      64'd0);
    chk("rst_wr_address", 64'(ram_wr_address), 64'd0);
    chk("rst_data_in",    ram_data_in,         64'd0);
    chk("rst_ram_read",   64'(ram_read),       64'd0);
    chk("rst_rd_address", 64'(ram_rd_address), 64'd0);
    chk("rst_rsp_valid",  64'(rsp_valid),      64'd0);
    chk("rst_rsp_last",   64'(rsp_last),       64'd0);
    chk("rst_rsp_data",   rsp_data,            64'd0);
    resetn = 1'b1;
    tick();

    do_write(12'h010, 8'd3, 64'hA0);
    do_read (12'h010, 8'd3, 64'hA0);

    do_write(12'hFFE, 8'd3, 64'hB0);
    do_read (12'hFFE, 8'd3, 64'hB0);

    // Stalled write: wr_valid pattern 1,0,0,1,1,0,1 (bit p = cycle p).
    stall_pat = 7'b1011001;
    b = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h100; cmd_len = 8'd3; wr_valid = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int p = 0; p < 7; p++) begin
      wr_valid = stall_pat[p];
      wr_data  = 64'hC0 + 64'(b);
      tick();
      chk("stall_ram_write", 64'(ram_write), 64'(stall_pat[p]));
      if (stall_pat[p]) begin
        chk("stall_address", 64'(ram_wr_address), 64'h100 + 64'(b));
        chk("stall_data",    ram_data_in,         64'hC0 + 64'(b));
        b++;
      end
      chk("stall_busy", 64'(busy), 64'(p != 6));
    end
    wr_valid = 1'b0;
    do_read(12'h100, 8'd3, 64'hC0);

    // Reset two cycles into an 8-beat read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010; cmd_len = 8'd7;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("abort_rd_1", 64'(ram_read), 64'd1);
    tick();
    chk("abort_rd_2", 64'(ram_read), 64'd1);
    resetn = 1'b0;
    #1;
    chk("abort_ram_read",   64'(ram_read),       64'd0);
    chk("abort_rd_address", 64'(ram_rd_address), 64'd0);
    chk("abort_busy",       64'(busy),           64'd0);
    chk("abort_rsp_valid",  64'(rsp_valid),      64'd0);
    chk("abort_ram_write",  64'(ram_write),      64'd0);
    tick();
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_abort_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_abort_ram_read",  64'(ram_read),  64'd0);
      chk("post_abort_cmd_ready", 64'(cmd_ready), 64'd1);
    end

    // RD_LATENCY = 3, single beat.
    cmd_valid3 = 1'b1; cmd_write3 = 1'b0; cmd_addr3 = 12'h055; cmd_len3 = 8'd0;
    tick();
    cmd_valid3 = 1'b0;
    chk("l3_accept_cmd_ready", 64'(cmd_ready3), 64'd0);
    for (int j = 0; j <= 5; j++) begin
      tick();
      chk("l3_ram_read",  64'(ram_read3),  64'(j == 0));
      if (j == 0) chk("l3_address", 64'(ram_rd_address3), 64'h055);
      chk("l3_rsp_valid", 64'(rsp_valid3), 64'(j == 4));
      if (j == 4) begin
        chk("l3_rsp_data", rsp_data3,         64'hC0DE_0000_0000_0055);
        chk("l3_rsp_last", 64'(rsp_last3),    64'd1);
      end
      chk("l3_cmd_ready", 64'(cmd_ready3), 64'(j == 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_initiator.md
Name: ram_initiator

Overview:
- Command-driven bus master for the dual-port `ram_4096` memory. It sits between a stimulus or processing block and the RAM's write and read ports.
- It accepts one burst command at a time over a valid/ready handshake. Write bursts are streamed into the RAM; read bursts are issued one address per cycle, and the returned data is presented on a response stream.
- It provides the missing initiator end of the RAM interface, so the RAM can be driven by RTL rather than only by the testbench.

Parameters:
- DATA_WIDTH, 64, width of RAM data words and of the wr_data/rsp_data streams.
- ADDR_WIDTH, 12, RAM address width (4096 words).
- RD_LATENCY, 1, cycles from the RAM sampling ram_read to valid ram_data_out; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  burst start address.
- cmd_len  in  8  beats minus one (0..255 gives 1..256 beats).
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write beat accepted when wr_valid is also high.
- wr_data  in  DATA_WIDTH  write beat data.
- rsp_valid  out  1  read response beat; no backpressure, the consumer must always accept.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_last  out  1  final beat of a read burst.
- busy  out  1  high whenever state is not IDLE.
- ram_write  out  1  RAM write strobe.
- ram_wr_address  out  ADDR_WIDTH  RAM write address.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_read  out  1  RAM read strobe.
- ram_rd_address  out  ADDR_WIDTH  RAM read address.
- ram_data_out  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset: state IDLE, beat counter and address registers 0, latency pipeline cleared.
  - All outputs 0 except cmd_ready, which is 1.
  - Reset mid-burst abandons the burst; in-flight reads produce no rsp_valid.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - A command is accepted when cmd_valid & cmd_ready at an edge. Latch addr = cmd_addr and remaining = cmd_len.
  - Go to WRITE if cmd_write, else READ. cmd_ready drops in the next cycle.
- WRITE:
  - wr_ready = 1.
  - Each accepted beat (wr_valid & wr_ready) registers the RAM outputs: in the following cycle ram_write = 1, ram_wr_address = addr, ram_data_in = wr_data.
  - After each beat, addr increments modulo 2^ADDR_WIDTH (4095 wraps to 0).
  - Idle wr_valid cycles stall the burst: ram_write = 0 in the next cycle, no timeout.
  - The beat with remaining == 0 returns the FSM to IDLE. wr_ready is 0 in the next cycle; ram_write for that last beat occurs in that same cycle.
  - ram_wr_address and ram_data_in hold their last values when ram_write = 0.
- READ:
  - One read per cycle, unconditionally: registered ram_read = 1, ram_rd_address = addr, then addr increments with wrap.
  - After the issue with remaining == 0, go to DRAIN. The cycle after the last issue has ram_read = 0.
- Response path:
  - A RD_LATENCY-deep shift register carries ram_read and a last flag.
  - When its tail is set, ram_data_out is registered into rsp_data, and rsp_valid and rsp_last are asserted in the next cycle.
  - A read strobe high in cycle k therefore yields rsp_valid in cycle k + RD_LATENCY + 1.
  - rsp_last accompanies exactly the beat of the final address.
  - rsp_data holds its value when rsp_valid = 0.
- DRAIN: waits until the pipeline is empty and the last response is registered, then goes to IDLE.
- Ordering: a new command is accepted only in IDLE. A read issued after a write burst therefore always observes the written data; no read-after-write hazard exists.
- cmd_* inputs are ignored outside IDLE; wr_* inputs are ignored outside WRITE.
- cmd_valid held in IDLE: back-to-back commands have exactly one IDLE cycle between bursts.

Test Plan:
- Reset, then write burst cmd_addr = 0x010, cmd_len = 3, data 0xA0..0xA3 with wr_valid held high → ram_write high 4 consecutive cycles at addresses 0x010..0x013; cmd_ready low during the burst; busy falls after the last beat.
- Read burst cmd_addr = 0x010, cmd_len = 3 after the above, RD_LATENCY = 1 → ram_read at 0x010..0x013; rsp_valid 4 cycles starting 2 cycles after the first ram_read; rsp_data 0xA0..0xA3; rsp_last only on 0xA3.
- Wrap-around: write cmd_addr = 0xFFE, cmd_len = 3 → ram_wr_address sequence 0xFFE, 0xFFF, 0x000, 0x001; readback returns the same data in order.
- Stalled write: wr_valid toggles 1,0,0,1,1,0,1 for a 4-beat burst → exactly 4 ram_write pulses, each one cycle after an accepted beat; no writes in gap cycles.
- Reset mid-read: assert resetn = 0 two cycles into an 8-beat read → all outputs immediately 0, cmd_ready = 1 after release; no rsp_valid ever appears for the aborted burst.
- RD_LATENCY = 3 and cmd_len = 0 → one ram_read, rsp_valid exactly 4 cycles later with rsp_last = 1; cmd_ready returns the cycle after DRAIN completes.
